// File: rtl/spi_display_receiver.sv
// SPI slave that receives 16-bit address/data command words and keeps the display register file.
// Optional macro BCD_DECODE_EN enables Code-B digit decoding on the segment read port.
module spi_display_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_seg,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown,
  output logic       display_test,
  output logic       word_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ERR} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic [15:0]            shift_q, shift_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [7:0]             digit_q [8];
  logic [7:0]             decode_mode_q;
  logic [3:0]             intensity_q;
  logic [2:0]             scan_limit_q;
  logic                   shutdown_q, display_test_q;
  logic                   word_valid_q, frame_err_q;

  logic sck_s, mosi_s, cs_s;
  logic sck_rise, cs_rise, cs_fall;
  logic [2:0] wr_idx;
  logic unused_msb;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // Address nibble 1..8 maps to digit 0..7; 3-bit wrap turns address 8 into index 7.
  assign wr_idx = shift_d[10:8] - 3'd1;

  // The oldest bit falls out of the register; the upper address nibble is don't-care anyway.
  assign unused_msb = shift_q[15];

  // Synchronisers; cs resets low so a cs still held low after reset never looks like a falling edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  // The bit arriving with a cs rise is shifted and counted before the length check.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (sck_rise) begin
      shift_d = {shift_q[14:0], mosi_s};
      cnt_d   = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      decode_mode_q  <= '0;
      intensity_q    <= '0;
      scan_limit_q   <= '0;
      shutdown_q     <= 1'b1;
      display_test_q <= 1'b0;
      word_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_d;
          if (cs_rise) begin
            if (cnt_d == 5'd16) begin
              state_q      <= COMMIT;
              word_valid_q <= 1'b1;
              case (shift_d[11:8])
                4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8: digit_q[wr_idx] <= shift_d[7:0];
                4'h9: decode_mode_q  <= shift_d[7:0];
                4'hA: intensity_q    <= shift_d[3:0];
                4'hB: scan_limit_q   <= shift_d[2:0];
                4'hC: shutdown_q     <= ~shift_d[0];
                4'hF: display_test_q <= shift_d[0];
                default: ;
              endcase
            end else begin
              state_q     <= ERR;
              frame_err_q <= 1'b1;
            end
          end
        end
        COMMIT:  state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BCD_DECODE_EN
  function automatic logic [6:0] code_b(input logic [3:0] v);
    case (v)
      4'h0: code_b = 7'h7E;
      4'h1: code_b = 7'h30;
      4'h2: code_b = 7'h6D;
      4'h3: code_b = 7'h79;
      4'h4: code_b = 7'h33;
      4'h5: code_b = 7'h5B;
      4'h6: code_b = 7'h5F;
      4'h7: code_b = 7'h70;
      4'h8: code_b = 7'h7F;
      4'h9: code_b = 7'h7B;
      4'hA: code_b = 7'h01;
      4'hB: code_b = 7'h4F;
      4'hC: code_b = 7'h37;
      4'hD: code_b = 7'h0E;
      4'hE: code_b = 7'h67;
      default: code_b = 7'h00;
    endcase
  endfunction
`endif

  always_comb begin
    rd_seg = digit_q[rd_addr];
    if (display_test_q) begin
      rd_seg = 8'hFF;
    end else if (shutdown_q) begin
      rd_seg = 8'h00;
    end else begin
`ifdef BCD_DECODE_EN
      if (decode_mode_q[rd_addr]) rd_seg = {digit_q[rd_addr][7], code_b(digit_q[rd_addr][3:0])};
`endif
    end
  end

  assign decode_mode  = decode_mode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign shutdown     = shutdown_q;
  assign display_test = display_test_q;
  assign word_valid   = word_valid_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_display_receiver.sv
// Randomised self-checking bench for spi_display_receiver against a register-file reference model.
module tb_spi_display_receiver;

  logic       clk = 1'b0;
  logic       res, sck, mosi, cs;
  logic [2:0] rd_addr;
  logic [7:0] rd_seg, decode_mode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown, display_test, word_valid, frame_err;

  spi_display_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .res(res), .sck(sck), .mosi(mosi), .cs(cs), .rd_addr(rd_addr),
    .rd_seg(rd_seg), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown(shutdown), .display_test(display_test),
    .word_valid(word_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int wv_cnt   = 0;
  int fe_cnt   = 0;

  always @(posedge clk) begin
    if (word_valid) wv_cnt <= wv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  // Reference model of the display register file
  logic [7:0] m_dig [8];
  logic [7:0] m_dm;
  logic [3:0] m_int;
  logic [2:0] m_sl;
  logic       m_shut, m_dt;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
    m_dm = 8'h00; m_int = 4'h0; m_sl = 3'h0; m_shut = 1'b1; m_dt = 1'b0;
  endfunction

  function automatic void model_apply(input logic [15:0] w);
    int a;
    a = int'(w[11:8]);
    if (a >= 1 && a <= 8) m_dig[a-1] = w[7:0];
    else if (a == 9)  m_dm   = w[7:0];
    else if (a == 10) m_int  = w[3:0];
    else if (a == 11) m_sl   = w[2:0];
    else if (a == 12) m_shut = ~w[0];
    else if (a == 15) m_dt   = w[0];
  endfunction

  function automatic logic [7:0] model_seg(input int a);
    logic [7:0] tbl [16];
    tbl = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
            8'h7F, 8'h7B, 8'h01, 8'h4F, 8'h37, 8'h0E, 8'h67, 8'h00};
    if (m_dt) return 8'hFF;
    if (m_shut) return 8'h00;
`ifdef BCD_DECODE_EN
    if (m_dm[a]) return tbl[m_dig[a][3:0]] | {m_dig[a][7], 7'b0};
`endif
    return m_dig[a];
  endfunction

  task automatic send_bits(input logic [16:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk) mosi = d[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [16:0] d, input int n);
    @(negedge clk) cs = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(d, n);
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    if (n == 16) model_apply(d[15:0]);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (word_valid !== 1'b0) $display("FAIL reset_wv got %b want 0", word_valid); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_fe got %b want 0", frame_err); else n_pass++;
    n_checks++; if ({decode_mode, intensity, scan_limit, shutdown, display_test} !== {8'h00, 4'h0, 3'h0, 1'b1, 1'b0})
      $display("FAIL reset_regs got %h/%h/%h/%b/%b want 00/0/0/1/0", decode_mode, intensity, scan_limit, shutdown, display_test);
    else n_pass++;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a); #1;
      n_checks++; if (rd_seg !== 8'h00) $display("FAIL reset_seg[%0d] got %h want 00", a, rd_seg); else n_pass++;
    end
  endtask

  task automatic test_shutdown_latency();
    int wv0, fe0;
    wv0 = wv_cnt; fe0 = fe_cnt;
    @(negedge clk) cs = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(17'h00C01, 16);
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({word_valid, shutdown} !== 2'b01) $display("FAIL lat_early wv/shut got %b%b want 01", word_valid, shutdown); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({word_valid, shutdown} !== 2'b10) $display("FAIL lat_commit wv/shut got %b%b want 10", word_valid, shutdown); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (word_valid !== 1'b0) $display("FAIL lat_pulse wv got %b want 0", word_valid); else n_pass++;
    repeat (6) @(negedge clk);
    model_apply(16'h0C01);
    n_checks++; if (wv_cnt - wv0 !== 1 || fe_cnt - fe0 !== 0) $display("FAIL shut_pulses wv %0d fe %0d want 1 0", wv_cnt - wv0, fe_cnt - fe0); else n_pass++;
  endtask

  task automatic test_bcd();
    logic [7:0] want;
    do_frame(17'h00C01, 16);
    do_frame(17'h009FF, 16);
    do_frame(17'h00185, 16);
`ifdef BCD_DECODE_EN
    want = 8'hDB;
`else
    want = 8'h85;
`endif
    rd_addr = 3'd0; #1;
    n_checks++; if (rd_seg !== want) $display("FAIL bcd_seg got %h want %h", rd_seg, want); else n_pass++;
    n_checks++; if (decode_mode !== 8'hFF) $display("FAIL bcd_dm got %h want ff", decode_mode); else n_pass++;
  endtask

  task automatic test_bad_length();
    int wv0, fe0;
    do_frame(17'h00C00, 16);
    wv0 = wv_cnt; fe0 = fe_cnt;
    do_frame(17'h00C01 >> 1, 15);
    n_checks++; if (fe_cnt - fe0 !== 1 || wv_cnt - wv0 !== 0) $display("FAIL short_pulses fe %0d wv %0d want 1 0", fe_cnt - fe0, wv_cnt - wv0); else n_pass++;
    n_checks++; if (shutdown !== 1'b1) $display("FAIL short_shut got %b want 1", shutdown); else n_pass++;
    wv0 = wv_cnt; fe0 = fe_cnt;
    do_frame(17'h10C01, 17);
    n_checks++; if (fe_cnt - fe0 !== 1 || wv_cnt - wv0 !== 0) $display("FAIL long_pulses fe %0d wv %0d want 1 0", fe_cnt - fe0, wv_cnt - wv0); else n_pass++;
    n_checks++; if ({shutdown, intensity, scan_limit} !== {m_shut, m_int, m_sl}) $display("FAIL long_regs got %b/%h/%h want %b/%h/%h", shutdown, intensity, scan_limit, m_shut, m_int, m_sl); else n_pass++;
  endtask

  task automatic test_display_test();
    do_frame(17'h00F01, 16);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a); #1;
      n_checks++; if (rd_seg !== 8'hFF) $display("FAIL dtest_on[%0d] got %h want ff", a, rd_seg); else n_pass++;
    end
    do_frame(17'h00F00, 16);
    rd_addr = 3'd0; #1;
    n_checks++; if (rd_seg !== 8'h00) $display("FAIL dtest_off got %h want 00", rd_seg); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int wv0, fe0;
    wv0 = wv_cnt; fe0 = fe_cnt;
    @(negedge clk) cs = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(17'h00003, 8);
    @(negedge clk) res = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    model_reset();
    send_bits(17'h00001, 8);
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++; if (wv_cnt - wv0 !== 0 || fe_cnt - fe0 !== 0) $display("FAIL midres_pulses wv %0d fe %0d want 0 0", wv_cnt - wv0, fe_cnt - fe0); else n_pass++;
    n_checks++; if (shutdown !== 1'b1) $display("FAIL midres_shut got %b want 1", shutdown); else n_pass++;
    do_frame(17'h00C01, 16);
    do_frame(17'h00406, 16);
    rd_addr = 3'd3; #1;
    n_checks++; if (rd_seg !== 8'h06) $display("FAIL midres_dig3 got %h want 06", rd_seg); else n_pass++;
    rd_addr = 3'd2; #1;
    n_checks++; if (rd_seg !== 8'h00) $display("FAIL midres_dig2 got %h want 00", rd_seg); else n_pass++;
  endtask

  task automatic test_random();
    logic [16:0] w;
    int n, wv0, fe0;
    for (int it = 0; it < 40; it++) begin
      w = 17'($urandom);
      if (w[11:8] == 4'hF) w[0] = ($urandom_range(0, 3) == 0);
      if (w[11:8] == 4'hC) w[0] = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      wv0 = wv_cnt; fe0 = fe_cnt;
      do_frame(w, n);
      n_checks++; if (wv_cnt - wv0 !== ((n == 16) ? 1 : 0) || fe_cnt - fe0 !== ((n == 16) ? 0 : 1))
        $display("FAIL rnd%0d_pulses n=%0d wv %0d fe %0d", it, n, wv_cnt - wv0, fe_cnt - fe0);
      else n_pass++;
      n_checks++; if ({decode_mode, intensity, scan_limit, shutdown, display_test} !== {m_dm, m_int, m_sl, m_shut, m_dt})
        $display("FAIL rnd%0d_regs got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", it, decode_mode, intensity, scan_limit,
                 shutdown, display_test, m_dm, m_int, m_sl, m_shut, m_dt);
      else n_pass++;
      for (int a = 0; a < 8; a++) begin
        rd_addr = 3'(a); #1;
        n_checks++; if (rd_seg !== model_seg(a)) $display("FAIL rnd%0d_seg[%0d] got %h want %h", it, a, rd_seg, model_seg(a)); else n_pass++;
      end
    end
  endtask

  initial begin
    res = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b1; rd_addr = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    res = 1'b0;
    repeat (6) @(negedge clk);
    test_reset();
    test_shutdown_latency();
    test_bcd();
    test_bad_length();
    test_display_test();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
